// File: rtl/periph_bus_arbiter_pkg.sv
// periph_bus_arbiter_pkg: device map, window sizes and FSM encoding shared by the peripheral bus slice
package periph_bus_arbiter_pkg;
   localparam logic [31:0] T0_BASE = 32'h0000_7F00;
   localparam logic [31:0] T1_BASE = 32'h0000_7F10;
   localparam logic [31:0] D2_BASE = 32'h0000_7F20;
   localparam int unsigned T0_WORDS = 3;
   localparam int unsigned T1_WORDS = 3;
   localparam int unsigned D2_WORDS = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_e;
   // word address hits a device when it is in the base's 16-byte block and below the window size
   function automatic logic win_hit(input logic [29:0] wa, input logic [31:0] base, input int unsigned words);
      return (wa[29:2] == base[31:4]) && (32'(wa[1:0]) < words);
   endfunction
endpackage

// File: rtl/periph_bus_arbiter_addr_decode.sv
// periph_addr_decode: word address -> one-hot device target {dev2,t1,t0} plus unmapped flag
module periph_addr_decode
   import periph_bus_arbiter_pkg::*;
(
   input  logic [29:0] word_addr_i,
   output logic [2:0]  target_o,
   output logic        unmapped_o
);
   assign target_o = {win_hit(word_addr_i, D2_BASE, D2_WORDS),
                      win_hit(word_addr_i, T1_BASE, T1_WORDS),
                      win_hit(word_addr_i, T0_BASE, T0_WORDS)};
   assign unmapped_o = ~|target_o;
endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin access sequencer for the timer/dev2 peripheral bus, plus IRQ registering
module periph_bus_arbiter
   import periph_bus_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic        m0_we,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic        m1_we,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] rdata,
   output logic [29:0] dev_addr,
   output logic [31:0] dev_wdata,
   output logic [2:0]  dev_we,
   input  logic [31:0] dev_rdata0,
   input  logic [31:0] dev_rdata1,
   input  logic [31:0] dev_rdata2,
   input  logic [2:0]  dev_irq,
   output logic [5:0]  hwint
);
   state_e      state_q;
   logic        last_grant_q, win_q, err_q;
   logic        m0_ack_q, m1_ack_q, m0_err_q, m1_err_q;
   logic [2:0]  tgt_q, dev_we_q;
   logic [29:0] dev_addr_q;
   logic [31:0] dev_wdata_q, rdata_q;
   logic [5:0]  hwint_q;
   logic        winner, sel_we, unmapped;
   logic [29:0] sel_word;
   logic [31:0] sel_wdata;
   logic [2:0]  tgt;
   logic        unused_addr_lsbs;
   // a lone requester wins; on a tie the master that did not win last time goes
   assign winner    = (m0_req & m1_req) ? ~last_grant_q : m1_req;
   assign sel_word  = winner ? m1_addr[31:2] : m0_addr[31:2];
   assign sel_we    = winner ? m1_we : m0_we;
   assign sel_wdata = winner ? m1_wdata : m0_wdata;
   assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};
   periph_addr_decode u_decode (
      .word_addr_i (sel_word),
      .target_o    (tgt),
      .unmapped_o  (unmapped)
   );
   // access sequencer: grant in IDLE, strobe device in XFER, pulse ack with captured read data in RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         win_q        <= 1'b0;
         err_q        <= 1'b0;
         tgt_q        <= '0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
         dev_we_q     <= '0;
         dev_addr_q   <= '0;
         dev_wdata_q  <= '0;
         rdata_q      <= '0;
      end else begin
         m0_ack_q <= 1'b0;
         m1_ack_q <= 1'b0;
         m0_err_q <= 1'b0;
         m1_err_q <= 1'b0;
         dev_we_q <= '0;
         case (state_q)
            IDLE: if (m0_req | m1_req) begin
               win_q        <= winner;
               last_grant_q <= winner;
               tgt_q        <= tgt;
               err_q        <= unmapped;
               dev_addr_q   <= sel_word;
               dev_wdata_q  <= sel_wdata;
               dev_we_q     <= sel_we ? tgt : 3'b000;
               state_q      <= XFER;
            end
            XFER: begin
               rdata_q  <= tgt_q[0] ? dev_rdata0 : tgt_q[1] ? dev_rdata1 : tgt_q[2] ? dev_rdata2 : 32'd0;
               m0_ack_q <= ~win_q;
               m1_ack_q <= win_q;
               m0_err_q <= ~win_q & err_q;
               m1_err_q <= win_q & err_q;
               state_q  <= RESP;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // device IRQs are re-timed into the CPU interrupt vector every cycle
   always_ff @(posedge clk) begin
      hwint_q <= reset ? 6'd0 : {3'b000, dev_irq};
   end
   assign m0_ack    = m0_ack_q;
   assign m1_ack    = m1_ack_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;
   assign rdata     = rdata_q;
   assign dev_addr  = dev_addr_q;
   assign dev_wdata = dev_wdata_q;
   assign dev_we    = dev_we_q;
   assign hwint     = hwint_q;
endmodule
